// File: rtl/exec_sequencer_if.sv
// Bus bundle between the exec_sequencer and its environment (instruction
// memory, register file and the control that starts or steps the program).
// The sequencer connects through the slave modport; the environment, or a
// bench, drives the master modport.
interface exec_sequencer_if;
    logic        i_start;
    logic [15:0] i_instr;
    logic        i_instr_valid;
    logic        i_step;
    logic [7:0]  o_pc;
    logic        o_fetch_req;
    logic [3:0]  o_rd_add_1;
    logic [3:0]  o_rd_add_2;
    logic [3:0]  o_opcode;
    logic [3:0]  o_destadd;
    logic        o_write_en;
    logic        o_busy;
    logic        o_halted;
    logic [7:0]  o_retired;

    modport master (
        output i_start, i_instr, i_instr_valid, i_step,
        input  o_pc, o_fetch_req, o_rd_add_1, o_rd_add_2, o_opcode,
               o_destadd, o_write_en, o_busy, o_halted, o_retired
    );

    modport slave (
        input  i_start, i_instr, i_instr_valid, i_step,
        output o_pc, o_fetch_req, o_rd_add_1, o_rd_add_2, o_opcode,
               o_destadd, o_write_en, o_busy, o_halted, o_retired
    );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle instruction sequencer.
// Each instruction runs FETCH (waits for the memory ack), then DECODE,
// EXEC and WB, one cycle each. Opcode 4'hF halts; opcode 4'h0 is a NOP
// whose write strobe is suppressed. Every output is a register.
//
// Optional feature: define SEQ_STEP_EN for single-step operation. With it,
// a fetch is only requested and accepted while a step pulse is pending.
// Without it, i_step is ignored and the program runs freely.
module exec_sequencer (
    input  logic            i_clk,
    input  logic            i_reset,
    exec_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_HALT = 4'hF;

    // Retired-instruction counter increment that sticks at all-ones.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        if (value == 8'hFF) begin
            sat_inc = 8'hFF;
        end else begin
            sat_inc = value + 8'd1;
        end
    endfunction

    state_t      state_r,     state_nxt_s;
    logic [7:0]  pc_r,        pc_nxt_s;
    logic [15:0] ir_r,        ir_nxt_s;
    logic [7:0]  retired_r,   retired_nxt_s;
    logic [3:0]  rd1_r,       rd1_nxt_s;
    logic [3:0]  rd2_r,       rd2_nxt_s;
    logic [3:0]  opcode_r,    opcode_nxt_s;
    logic [3:0]  dest_r,      dest_nxt_s;
    logic        we_r,        we_nxt_s;
    logic        fetch_req_r, fetch_req_nxt_s;
    logic        busy_r,      busy_nxt_s;
    logic        halted_r,    halted_nxt_s;

    logic        restart_s;
    logic        ack_s;
    logic        fetch_gate_s;
    logic        fetch_gate_nxt_s;

    // A restart is only honoured while idle or halted.
    assign restart_s = bus.i_start &&
                       ((state_r == ST_IDLE) || (state_r == ST_HALT));

`ifdef SEQ_STEP_EN
    logic step_pending_r;
    logic step_pending_nxt_s;

    // Next value of the step flag: a restart or a fetch ack consumes it.
    always_comb begin
        step_pending_nxt_s = step_pending_r;
        if (restart_s || ack_s) begin
            step_pending_nxt_s = 1'b0;
        end else if (bus.i_step) begin
            step_pending_nxt_s = 1'b1;
        end else begin
            step_pending_nxt_s = step_pending_r;
        end
    end

    // Step flag storage.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            step_pending_r <= 1'b0;
        end else begin
            step_pending_r <= step_pending_nxt_s;
        end
    end

    assign fetch_gate_s     = step_pending_r;
    assign fetch_gate_nxt_s = step_pending_nxt_s;
`else
    logic step_unused_s;

    assign step_unused_s    = bus.i_step;
    assign fetch_gate_s     = 1'b1;
    assign fetch_gate_nxt_s = 1'b1;
`endif

    // Memory ack only counts in FETCH, and only while fetching is enabled.
    assign ack_s = (state_r == ST_FETCH) && bus.i_instr_valid && fetch_gate_s;

    // Next-state and next-output computation. Outputs are computed for the
    // state being entered, so they are valid during that state.
    always_comb begin
        state_nxt_s   = state_r;
        pc_nxt_s      = pc_r;
        ir_nxt_s      = ir_r;
        retired_nxt_s = retired_r;
        rd1_nxt_s     = rd1_r;
        rd2_nxt_s     = rd2_r;
        opcode_nxt_s  = opcode_r;
        dest_nxt_s    = dest_r;
        we_nxt_s      = 1'b0;

        case (state_r)
            ST_IDLE, ST_HALT: begin
                if (bus.i_start) begin
                    state_nxt_s   = ST_FETCH;
                    pc_nxt_s      = 8'h00;
                    retired_nxt_s = 8'h00;
                end else begin
                    state_nxt_s   = state_r;
                end
            end
            ST_FETCH: begin
                if (ack_s) begin
                    ir_nxt_s = bus.i_instr;
                    if (bus.i_instr[15:12] == OP_HALT) begin
                        state_nxt_s = ST_HALT;
                    end else begin
                        state_nxt_s = ST_DECODE;
                        rd1_nxt_s   = bus.i_instr[7:4];
                        rd2_nxt_s   = bus.i_instr[3:0];
                    end
                end else begin
                    state_nxt_s = ST_FETCH;
                end
            end
            ST_DECODE: begin
                state_nxt_s  = ST_EXEC;
                rd1_nxt_s    = ir_r[7:4];
                rd2_nxt_s    = ir_r[3:0];
                opcode_nxt_s = ir_r[15:12];
                dest_nxt_s   = ir_r[11:8];
            end
            ST_EXEC: begin
                state_nxt_s = ST_WB;
                we_nxt_s    = (ir_r[15:12] != OP_NOP);
            end
            ST_WB: begin
                state_nxt_s   = ST_FETCH;
                pc_nxt_s      = pc_r + 8'd1;
                retired_nxt_s = sat_inc(retired_r);
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        busy_nxt_s      = (state_nxt_s == ST_FETCH)  || (state_nxt_s == ST_DECODE) ||
                          (state_nxt_s == ST_EXEC)   || (state_nxt_s == ST_WB);
        halted_nxt_s    = (state_nxt_s == ST_HALT);
        fetch_req_nxt_s = (state_nxt_s == ST_FETCH) && fetch_gate_nxt_s;
    end

    // Sequencer state and registered outputs; reset clears everything,
    // including a write strobe that was about to be issued.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_r     <= ST_IDLE;
            pc_r        <= 8'h00;
            ir_r        <= 16'h0000;
            retired_r   <= 8'h00;
            rd1_r       <= 4'h0;
            rd2_r       <= 4'h0;
            opcode_r    <= 4'h0;
            dest_r      <= 4'h0;
            we_r        <= 1'b0;
            fetch_req_r <= 1'b0;
            busy_r      <= 1'b0;
            halted_r    <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            pc_r        <= pc_nxt_s;
            ir_r        <= ir_nxt_s;
            retired_r   <= retired_nxt_s;
            rd1_r       <= rd1_nxt_s;
            rd2_r       <= rd2_nxt_s;
            opcode_r    <= opcode_nxt_s;
            dest_r      <= dest_nxt_s;
            we_r        <= we_nxt_s;
            fetch_req_r <= fetch_req_nxt_s;
            busy_r      <= busy_nxt_s;
            halted_r    <= halted_nxt_s;
        end
    end

    assign bus.o_pc        = pc_r;
    assign bus.o_fetch_req = fetch_req_r;
    assign bus.o_rd_add_1  = rd1_r;
    assign bus.o_rd_add_2  = rd2_r;
    assign bus.o_opcode    = opcode_r;
    assign bus.o_destadd   = dest_r;
    assign bus.o_write_en  = we_r;
    assign bus.o_busy      = busy_r;
    assign bus.o_halted    = halted_r;
    assign bus.o_retired   = retired_r;

endmodule
